// File: rtl/violation_reset_seq_pkg.sv
// Shared definitions for the violation reset sequencer: FSM encoding,
// violation request bit positions and the default pulse length.
package violation_reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_ASSERT       = 2'd1,
    ST_WAIT_HANDLER = 2'd2
  } state_e;

  localparam int VIOL_W         = 3;
  localparam int VIOL_XSTACK    = 0;
  localparam int VIOL_ACCESS    = 1;
  localparam int VIOL_ATOMIC    = 2;
  localparam int RST_CYCLES_DEF = 4;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/violation_reset_seq_timer.sv
// Down-counter that times the sys_rst pulse; done is high whenever the
// count has reached zero.
module rst_pulse_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       done
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == 8'd0);

endmodule

// File: rtl/violation_reset_seq.sv
// Turns security violation requests into a fixed-length CPU reset pulse,
// then waits for the CPU to re-enter its reset handler before re-arming.
module violation_reset_seq
  import violation_reset_seq_pkg::*;
#(
  parameter logic [15:0] RESET_HANDLER = 16'h0000,
  parameter int unsigned RST_CYCLES    = RST_CYCLES_DEF
) (
  input  logic              mclk,
  input  logic              puc_rst,
  input  logic [15:0]       pc,
  input  logic [VIOL_W-1:0] viol_req,
  input  logic              cause_clr,
  output logic              sys_rst,
  output logic [VIOL_W-1:0] viol_cause,
  output logic [7:0]        viol_cnt,
  output logic              busy
);

  localparam logic [7:0] LOAD_VAL = 8'(RST_CYCLES - 1);

  state_e            state_q, state_d;
  logic              load;
  logic              done;
  logic              sys_rst_q;
  logic [VIOL_W-1:0] cause_q, cause_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              any_viol;

  assign any_viol = |viol_req;

  rst_pulse_timer u_timer (
    .clk      (mclk),
    .rst      (puc_rst),
    .load     (load),
    .load_val (LOAD_VAL),
    .done     (done)
  );

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A new violation in WAIT_HANDLER outranks reaching the handler address.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_viol) begin
          state_d = ST_ASSERT;
          load    = 1'b1;
        end
      end
      ST_ASSERT: begin
        if (done) state_d = ST_WAIT_HANDLER;
      end
      ST_WAIT_HANDLER: begin
        if (any_viol) begin
          state_d = ST_ASSERT;
          load    = 1'b1;
        end else if (pc == RESET_HANDLER) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != ST_IDLE);
  end

  // Every load marks a new episode; cause_clr only acts in a quiet IDLE cycle.
  always_comb begin
    cnt_d   = load ? sat_inc8(cnt_q) : cnt_q;
    cause_d = cause_q | viol_req;
    if (state_q == ST_IDLE && cause_clr && !any_viol) begin
      cause_d = '0;
    end
  end

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      sys_rst_q <= 1'b0;
      cause_q   <= '0;
      cnt_q     <= 8'd0;
    end else begin
      sys_rst_q <= (state_d == ST_ASSERT);
      cause_q   <= cause_d;
      cnt_q     <= cnt_d;
    end
  end

  assign sys_rst    = sys_rst_q;
  assign viol_cause = cause_q;
  assign viol_cnt   = cnt_q;

endmodule

// File: tb/tb_violation_reset_seq.sv
// Scoreboard bench for violation_reset_seq: directed episodes followed by
// randomized traffic, checked against a behavioural episode model.
module tb_violation_reset_seq;

  localparam int          RC      = 4;
  localparam logic [15:0] HANDLER = 16'h0000;

  logic        mclk;
  logic        puc_rst;
  logic [15:0] pc;
  logic [2:0]  viol_req;
  logic        cause_clr;
  logic        sys_rst;
  logic [2:0]  viol_cause;
  logic [7:0]  viol_cnt;
  logic        busy;

  violation_reset_seq #(.RESET_HANDLER(HANDLER), .RST_CYCLES(RC)) dut (
    .mclk       (mclk),
    .puc_rst    (puc_rst),
    .pc         (pc),
    .viol_req   (viol_req),
    .cause_clr  (cause_clr),
    .sys_rst    (sys_rst),
    .viol_cause (viol_cause),
    .viol_cnt   (viol_cnt),
    .busy       (busy)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  typedef struct packed {
    logic       rst;
    logic       bsy;
    logic [2:0] cause;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   cyc        = 0;

  // Behavioural model: remaining reset cycles, waiting-for-handler flag,
  // accumulated cause and episode count.
  int         m_left    = 0;
  bit         m_waiting = 0;
  logic [2:0] m_cause   = 3'b000;
  int         m_cnt     = 0;

  task automatic model_step(input logic r, input logic [15:0] p,
                            input logic [2:0] q, input logic c);
    if (r) begin
      m_left = 0; m_waiting = 0; m_cause = 3'b000; m_cnt = 0;
    end else if (m_left == 0 && !m_waiting) begin
      if (q != 3'b000) begin
        m_left = RC; m_cause = m_cause | q;
        if (m_cnt < 255) m_cnt = m_cnt + 1;
      end else if (c) begin
        m_cause = 3'b000;
      end
    end else if (m_left > 0) begin
      m_cause = m_cause | q;
      m_left  = m_left - 1;
      if (m_left == 0) m_waiting = 1;
    end else begin
      if (q != 3'b000) begin
        m_left = RC; m_waiting = 0; m_cause = m_cause | q;
        if (m_cnt < 255) m_cnt = m_cnt + 1;
      end else if (p == HANDLER) begin
        m_waiting = 0;
      end
    end
  endtask

  task automatic cycle(input logic r, input logic [15:0] p,
                       input logic [2:0] q, input logic c);
    exp_t e;
    puc_rst = r; pc = p; viol_req = q; cause_clr = c;
    model_step(r, p, q, c);
    e.rst   = (m_left > 0);
    e.bsy   = (m_left > 0) || m_waiting;
    e.cause = m_cause;
    e.cnt   = 8'(m_cnt);
    exp_q.push_back(e);
    @(posedge mclk);
    #1;
  endtask

  always @(negedge mclk) begin
    exp_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{rst: sys_rst, bsy: busy, cause: viol_cause, cnt: viol_cnt};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL cyc%0d outputs: got rst=%b busy=%b cause=%b cnt=%0d, expected rst=%b busy=%b cause=%b cnt=%0d",
                 cyc, a.rst, a.bsy, a.cause, a.cnt, e.rst, e.bsy, e.cause, e.cnt);
      end
      cyc++;
    end
  end

  task automatic episode(input logic [2:0] q);
    cycle(0, 16'hE000, q, 0);
    for (int i = 0; i < RC; i++) cycle(0, 16'hE000, 3'b000, 0);
    cycle(0, HANDLER, 3'b000, 0);
  endtask

  initial begin
    puc_rst = 1; pc = 16'h0; viol_req = 0; cause_clr = 0;
    cycle(1, 16'h0, 3'b000, 0);
    cycle(1, 16'h0, 3'b111, 0);
    cycle(0, 16'h1234, 3'b000, 0);

    // single X_stack violation, atomicity joins at pulse cycle 2
    cycle(0, 16'h1234, 3'b001, 0);
    cycle(0, 16'h1234, 3'b000, 0);
    cycle(0, 16'h1234, 3'b100, 0);
    cycle(0, 16'h1234, 3'b000, 0);
    cycle(0, 16'h1234, 3'b000, 0);
    cycle(0, 16'hE000, 3'b000, 0);
    cycle(0, 16'hE000, 3'b000, 0);
    // access-control violation in the same cycle the handler is reached
    cycle(0, HANDLER, 3'b010, 0);
    for (int i = 0; i < RC; i++) cycle(0, 16'hE000, 3'b000, 0);
    cycle(0, HANDLER, 3'b000, 0);
    cycle(0, HANDLER, 3'b000, 1);
    cycle(0, 16'h1000, 3'b000, 0);

    // cause_clr collides with a new violation: violation wins
    cycle(0, 16'h1000, 3'b001, 1);
    cycle(0, 16'h1000, 3'b000, 1);
    // puc_rst at pulse cycle 2
    cycle(1, 16'h1000, 3'b010, 0);
    cycle(0, 16'h1000, 3'b000, 0);

    for (int i = 0; i < 260; i++) episode(3'($urandom_range(1, 7)));
    cycle(0, 16'h2000, 3'b000, 1);
    cycle(0, 16'h2000, 3'b000, 0);

    for (int i = 0; i < 3000; i++) begin
      logic [2:0]  q;
      logic [15:0] p;
      q = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      p = ($urandom_range(0, 2) == 0) ? HANDLER : 16'($urandom);
      cycle(($urandom_range(0, 149) == 0), p, q, ($urandom_range(0, 5) == 0));
    end

    @(negedge mclk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
